// File: rtl/conv_dec_pkg.sv
// Shared constants, FSM state type and branch helpers for the K=7, rate-1/3
// tail-biting Viterbi decoder (conv_viterbi_dec_bs).
package conv_dec_pkg;
    localparam int K      = 7;
    localparam int NSTATE = 1 << (K - 1);

    // Tap masks over {c0,c1,...,c6}; c0 (the new input bit) sits in bit 6.
    localparam logic [6:0] G0 = 7'b1011011;
    localparam logic [6:0] G1 = 7'b1111001;
    localparam logic [6:0] G2 = 7'b1110101;

    localparam logic [12:0] SIZE_SMALL = 13'd1056;
    localparam logic [12:0] SIZE_LARGE = 13'd6144;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } dec_state_e;

    function automatic logic [2:0] exp_sym(input logic [5:0] state, input logic u);
        logic [6:0] reg_v;
        reg_v = {u, state};
        return {^(reg_v & G0), ^(reg_v & G1), ^(reg_v & G2)};
    endfunction

    function automatic logic [1:0] hamming3(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] x;
        x = a ^ b;
        return 2'(x[0]) + 2'(x[1]) + 2'(x[2]);
    endfunction
endpackage

// File: rtl/conv_viterbi_dec_bs_if.sv
// Symbol-in / bit-out handshake bundle of conv_viterbi_dec_bs.
// master = symbol source and bit sink, slave = decoder.
interface conv_viterbi_dec_bs_if;
    logic       blk_size;
    logic       sym_valid;
    logic [2:0] sym_data;
    logic       sym_ready;
    logic       out_valid;
    logic       out_bit;
    logic       out_last;
    logic       busy;

    modport master (
        output blk_size, sym_valid, sym_data,
        input  sym_ready, out_valid, out_bit, out_last, busy
    );

    modport slave (
        input  blk_size, sym_valid, sym_data,
        output sym_ready, out_valid, out_bit, out_last, busy
    );
endinterface

// File: rtl/conv_dec_acs.sv
// Add-compare-select for one trellis state with register-exchange survivor.
// Ties keep the predecessor whose LSB is 0.
module conv_dec_acs #(
    parameter int   PM_W     = 6,
    parameter int   TB_DEPTH = 32,
    parameter logic U_BIT    = 1'b0
) (
    input  logic [PM_W-1:0]     pm0_i,
    input  logic [PM_W-1:0]     pm1_i,
    input  logic [1:0]          bm0_i,
    input  logic [1:0]          bm1_i,
    input  logic [TB_DEPTH-2:0] surv0_i,
    input  logic [TB_DEPTH-2:0] surv1_i,
    output logic [PM_W-1:0]     pm_o,
    output logic [TB_DEPTH-1:0] surv_o
);
    logic [PM_W-1:0] cand0_s;
    logic [PM_W-1:0] cand1_s;

    // Pick the cheaper candidate and shift this state's input bit into its survivor.
    always_comb begin
        cand0_s = pm0_i + PM_W'(bm0_i);
        cand1_s = pm1_i + PM_W'(bm1_i);
        if (cand1_s < cand0_s) begin
            pm_o   = cand1_s;
            surv_o = {surv1_i, U_BIT};
        end else begin
            pm_o   = cand0_s;
            surv_o = {surv0_i, U_BIT};
        end
    end
endmodule

// File: rtl/conv_viterbi_dec_bs.sv
// Hard-decision Viterbi decoder, rate 1/3, K=7, tail-biting, 64-state parallel ACS.
// Build option DEC_ERR_CNT_EN adds err_count (Hamming distance of the decoded path).
module conv_viterbi_dec_bs
    import conv_dec_pkg::*;
#(
    parameter int TB_DEPTH = 32,
    parameter int PM_W     = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    conv_viterbi_dec_bs_if.slave bus
`ifdef DEC_ERR_CNT_EN
    ,
    output logic [12:0]          err_count
`endif
);
    localparam int J_W = $clog2(TB_DEPTH);

    dec_state_e          state_q, state_d;
    logic [12:0]         count_q, count_d;
    logic [12:0]         n_last_q, n_last_d;
    logic [5:0]          best_q, best_d;
    logic [J_W-1:0]      flush_idx_q, flush_idx_d;
    logic [PM_W-1:0]     pm_q   [NSTATE];
    logic [PM_W-1:0]     pm_d   [NSTATE];
    logic [TB_DEPTH-1:0] surv_q [NSTATE];
    logic [TB_DEPTH-1:0] surv_d [NSTATE];
    logic                sym_ready_q, busy_q;
    logic                out_valid_q, out_valid_d;
    logic                out_bit_q, out_bit_d;
    logic                out_last_q, out_last_d;

    logic [PM_W-1:0]     pm_acs_s   [NSTATE];
    logic [PM_W-1:0]     pm_norm_s  [NSTATE];
    logic [TB_DEPTH-1:0] surv_acs_s [NSTATE];
    logic [PM_W-1:0]     min_s;
    logic [5:0]          best_s;
    logic                accept_s;

    assign accept_s = bus.sym_valid & sym_ready_q;

    // Next state s' is reached from {s'[4:0],0} and {s'[4:0],1}, with input bit s'[5].
    for (genvar s = 0; s < NSTATE; s++) begin : g_acs
        localparam int   P0    = (s % (NSTATE / 2)) * 2;
        localparam logic U_BIT = (s >= NSTATE / 2) ? 1'b1 : 1'b0;
        logic [1:0] bm0_s;
        logic [1:0] bm1_s;

        assign bm0_s = hamming3(bus.sym_data, exp_sym(6'(P0), U_BIT));
        assign bm1_s = hamming3(bus.sym_data, exp_sym(6'(P0 + 1), U_BIT));

        conv_dec_acs #(
            .PM_W     (PM_W),
            .TB_DEPTH (TB_DEPTH),
            .U_BIT    (U_BIT)
        ) u_acs (
            .pm0_i   (pm_q[P0]),
            .pm1_i   (pm_q[P0 + 1]),
            .bm0_i   (bm0_s),
            .bm1_i   (bm1_s),
            .surv0_i (surv_q[P0][TB_DEPTH-2:0]),
            .surv1_i (surv_q[P0 + 1][TB_DEPTH-2:0]),
            .pm_o    (pm_acs_s[s]),
            .surv_o  (surv_acs_s[s])
        );
    end

    // Minimum search, normalisation to 0, and lowest-index zero-metric state.
    always_comb begin
        min_s = pm_acs_s[0];
        for (int s = 1; s < NSTATE; s++) begin
            if (pm_acs_s[s] < min_s) min_s = pm_acs_s[s];
            else                     min_s = min_s;
        end
        for (int s = 0; s < NSTATE; s++) pm_norm_s[s] = pm_acs_s[s] - min_s;
        best_s = 6'd0;
        for (int s = NSTATE - 1; s >= 0; s--) begin
            if (pm_norm_s[s] == {PM_W{1'b0}}) best_s = 6'(s);
            else                              best_s = best_s;
        end
    end

    // Block FSM: IDLE -> RUN on first symbol, RUN -> FLUSH on symbol N-1, FLUSH drains.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        n_last_d    = n_last_q;
        best_d      = best_q;
        flush_idx_d = flush_idx_q;
        out_valid_d = 1'b0;
        out_bit_d   = 1'b0;
        out_last_d  = 1'b0;
        for (int s = 0; s < NSTATE; s++) begin
            pm_d[s]   = pm_q[s];
            surv_d[s] = surv_q[s];
        end
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    n_last_d = (bus.blk_size ? SIZE_LARGE : SIZE_SMALL) - 13'd1;
                    count_d  = 13'd1;
                    best_d   = best_s;
                    pm_d     = pm_norm_s;
                    surv_d   = surv_acs_s;
                    state_d  = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (accept_s) begin
                    best_d = best_s;
                    pm_d   = pm_norm_s;
                    surv_d = surv_acs_s;
                    if (count_q >= 13'(TB_DEPTH - 1)) begin
                        out_valid_d = 1'b1;
                        out_bit_d   = surv_acs_s[best_s][TB_DEPTH-1];
                    end else begin
                        out_valid_d = 1'b0;
                    end
                    if (count_q == n_last_q) begin
                        state_d     = FLUSH;
                        flush_idx_d = J_W'(TB_DEPTH - 2);
                    end else begin
                        count_d = count_q + 13'd1;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                out_valid_d = 1'b1;
                out_bit_d   = surv_q[best_q][flush_idx_q];
                if (flush_idx_q == {J_W{1'b0}}) begin
                    out_last_d = 1'b1;
                    state_d    = IDLE;
                    count_d    = 13'd0;
                    best_d     = 6'd0;
                    for (int s = 0; s < NSTATE; s++) begin
                        pm_d[s]   = {PM_W{1'b0}};
                        surv_d[s] = {TB_DEPTH{1'b0}};
                    end
                end else begin
                    flush_idx_d = flush_idx_q - {{(J_W-1){1'b0}}, 1'b1};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, metric, survivor and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            count_q     <= 13'd0;
            n_last_q    <= 13'd0;
            best_q      <= 6'd0;
            flush_idx_q <= {J_W{1'b0}};
            for (int s = 0; s < NSTATE; s++) begin
                pm_q[s]   <= {PM_W{1'b0}};
                surv_q[s] <= {TB_DEPTH{1'b0}};
            end
            sym_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            n_last_q    <= n_last_d;
            best_q      <= best_d;
            flush_idx_q <= flush_idx_d;
            pm_q        <= pm_d;
            surv_q      <= surv_d;
            sym_ready_q <= (state_d != FLUSH);
            busy_q      <= (state_d != IDLE);
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.sym_ready = sym_ready_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bit   = out_bit_q;
    assign bus.out_last  = out_last_q;

`ifdef DEC_ERR_CNT_EN
    logic [12:0] err_acc_q, err_acc_d;
    logic [12:0] err_count_q, err_count_d;

    // Summing each step's minimum gives the winning path's total distance.
    always_comb begin
        err_acc_d   = err_acc_q;
        err_count_d = err_count_q;
        if (accept_s) begin
            if (state_q == IDLE) err_acc_d = 13'(min_s);
            else                 err_acc_d = err_acc_q + 13'(min_s);
        end else begin
            err_acc_d = err_acc_q;
        end
        if (out_last_d) err_count_d = err_acc_q;
        else            err_count_d = err_count_q;
    end

    // Accumulator and published count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_acc_q   <= 13'd0;
            err_count_q <= 13'd0;
        end else begin
            err_acc_q   <= err_acc_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif
endmodule

// File: tb/tb_conv_viterbi_dec_bs.sv
// Bench for conv_viterbi_dec_bs: table of block scenarios checked against a
// tail-biting encoder model, plus a hand-written mid-block reset sequence.
module tb_conv_viterbi_dec_bs;
    localparam int TBD  = 32;
    localparam int NMAX = 6144;

    typedef struct {
        bit blk;
        bit zero_data;
        int gap_mode;     // 0 back-to-back, 1 alternate, 2 random gaps
        bit hold_flush;   // keep sym_valid high while the decoder flushes
        bit toggle_blk;   // wiggle blk_size after the first symbol
        int err0;         // symbol index to corrupt, -1 for none
        int err1;
        int exp_len;
        int exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    conv_viterbi_dec_bs_if bus();
`ifdef DEC_ERR_CNT_EN
    logic [12:0] err_count;
`endif

    conv_viterbi_dec_bs #(.TB_DEPTH(TBD), .PM_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef DEC_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    bit         data [NMAX];
    logic [2:0] syms [NMAX];

    bit cap_bits [$];
    int cap_cyc  [$];
    int mon_cyc  = 0;
    int last_cnt = 0;
    int last_pos = -1;

    always @(negedge clk) begin
        mon_cyc++;
        if (bus.out_valid === 1'b1) begin
            cap_bits.push_back(bus.out_bit);
            cap_cyc.push_back(mon_cyc);
        end
        if (bus.out_last === 1'b1) begin
            last_cnt++;
            last_pos = cap_bits.size() - 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tail-biting encoder: the register before step 0 holds the last six data bits.
    function automatic void make_block(input int n, input bit zero_data);
        for (int i = 0; i < n; i++) data[i] = zero_data ? 1'b0 : 1'($urandom_range(0, 1));
        for (int i = 0; i < n; i++) begin
            bit c [7];
            for (int j = 0; j < 7; j++) c[j] = data[(i - j + n) % n];
            syms[i] = {c[0] ^ c[2] ^ c[3] ^ c[5] ^ c[6],
                       c[0] ^ c[1] ^ c[2] ^ c[3] ^ c[6],
                       c[0] ^ c[1] ^ c[2] ^ c[4] ^ c[6]};
        end
    endfunction

    task automatic run_block(input vec_t v, input string tag);
        int n, k, guard, start, last0, acc31, mism, first_bad, nbits;
        bit vld, rdy;
        n = v.exp_len;
        make_block(n, v.zero_data);
        if (v.err0 >= 0) syms[v.err0] = syms[v.err0] ^ 3'(1 << $urandom_range(0, 2));
        if (v.err1 >= 0) syms[v.err1] = syms[v.err1] ^ 3'(1 << $urandom_range(0, 2));
        start = cap_bits.size();
        last0 = last_cnt;
        acc31 = -1;
        guard = 0;
        while (bus.sym_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        check({tag, " ready_at_start"}, int'(bus.sym_ready === 1'b1), 1);
        k = 0;
        guard = 0;
        while (k < n && guard < 4 * n) begin
            case (v.gap_mode)
                0:       vld = 1'b1;
                1:       vld = (guard % 2 == 0);
                default: vld = ($urandom_range(0, 3) != 0);
            endcase
            bus.sym_valid = vld;
            bus.sym_data  = vld ? syms[k] : 3'($urandom_range(0, 7));
            bus.blk_size  = (v.toggle_blk && k > 0) ? 1'($urandom_range(0, 1)) : v.blk;
            rdy = bus.sym_ready;
            tick();
            guard++;
            if (vld && rdy) begin
                if (k == TBD - 1) acc31 = mon_cyc;
                k++;
            end
        end
        check({tag, " symbols_accepted"}, k, n);
        check({tag, " flush_ready_low"}, int'(bus.sym_ready), 0);
        check({tag, " flush_busy_high"}, int'(bus.busy), 1);
        guard = 0;
        if (v.hold_flush) begin
            while (bus.sym_ready !== 1'b1 && guard < 4 * TBD) begin
                bus.sym_valid = 1'b1;
                bus.sym_data  = 3'($urandom_range(0, 7));
                tick();
                guard++;
            end
        end
        bus.sym_valid = 1'b0;
        while (last_cnt == last0 && guard < 4 * TBD) begin
            tick();
            guard++;
        end
        repeat (4) tick();
        check({tag, " idle_after_block"}, int'(bus.busy), 0);
        nbits = cap_bits.size() - start;
        check({tag, " bit_count"}, nbits, n);
        mism = 0;
        first_bad = -1;
        for (int i = 0; i < n && i < nbits; i++) begin
            if (cap_bits[start + i] != data[i]) begin
                if (first_bad < 0) first_bad = i;
                mism++;
            end
        end
        if (mism != 0) $display("  %s first wrong bit index %0d", tag, first_bad);
        check({tag, " wrong_bits"}, mism, 0);
        check({tag, " out_last_count"}, last_cnt - last0, 1);
        check({tag, " out_last_position"}, last_pos - start, n - 1);
        if (nbits > 0) check({tag, " first_out_latency"}, cap_cyc[start], acc31 + 1);
        else           check({tag, " first_out_present"}, nbits, 1);
`ifdef DEC_ERR_CNT_EN
        check({tag, " err_count"}, int'(err_count), v.exp_err);
`endif
    endtask

    initial begin
        vec_t tbl [6];
        vec_t fresh;
        int   last0, k;

        tbl[0] = '{blk:1'b0, zero_data:1'b1, gap_mode:0, hold_flush:1'b0, toggle_blk:1'b0,
                   err0:-1,  err1:-1,  exp_len:1056, exp_err:0};
        tbl[1] = '{blk:1'b1, zero_data:1'b0, gap_mode:0, hold_flush:1'b0, toggle_blk:1'b0,
                   err0:-1,  err1:-1,  exp_len:6144, exp_err:0};
        tbl[2] = '{blk:1'b0, zero_data:1'b0, gap_mode:0, hold_flush:1'b0, toggle_blk:1'b0,
                   err0:500, err1:900, exp_len:1056, exp_err:2};
        tbl[3] = '{blk:1'b0, zero_data:1'b0, gap_mode:1, hold_flush:1'b1, toggle_blk:1'b0,
                   err0:-1,  err1:-1,  exp_len:1056, exp_err:0};
        tbl[4] = '{blk:1'b1, zero_data:1'b0, gap_mode:2, hold_flush:1'b0, toggle_blk:1'b1,
                   err0:-1,  err1:-1,  exp_len:6144, exp_err:0};
        tbl[5] = '{blk:1'b0, zero_data:1'b0, gap_mode:0, hold_flush:1'b1, toggle_blk:1'b1,
                   err0:-1,  err1:-1,  exp_len:1056, exp_err:0};
        fresh  = '{blk:1'b0, zero_data:1'b0, gap_mode:0, hold_flush:1'b0, toggle_blk:1'b0,
                   err0:-1,  err1:-1,  exp_len:1056, exp_err:0};

        reset         = 1'b0;
        bus.sym_valid = 1'b0;
        bus.sym_data  = 3'd0;
        bus.blk_size  = 1'b0;
        repeat (3) tick();
        check("reset sym_ready", int'(bus.sym_ready), 0);
        check("reset out_valid", int'(bus.out_valid), 0);
        check("reset out_bit",   int'(bus.out_bit),   0);
        check("reset out_last",  int'(bus.out_last),  0);
        check("reset busy",      int'(bus.busy),      0);
`ifdef DEC_ERR_CNT_EN
        check("reset err_count", int'(err_count), 0);
`endif
        reset = 1'b1;
        tick();
        check("idle sym_ready", int'(bus.sym_ready), 1);
        check("idle busy",      int'(bus.busy),      0);

        for (int t = 0; t < 6; t++) run_block(tbl[t], $sformatf("vec%0d", t));

        // Abort a block with reset after 400 symbols, then decode a fresh one.
        make_block(1056, 1'b0);
        last0 = last_cnt;
        for (k = 0; k < 400; k++) begin
            bus.sym_valid = 1'b1;
            bus.sym_data  = syms[k];
            bus.blk_size  = 1'b0;
            tick();
        end
        check("abort out_valid before reset", int'(bus.out_valid), 1);
        check("abort busy before reset",      int'(bus.busy),      1);
        reset = 1'b0;
        #1;
        check("abort out_valid", int'(bus.out_valid), 0);
        check("abort out_bit",   int'(bus.out_bit),   0);
        check("abort out_last",  int'(bus.out_last),  0);
        check("abort busy",      int'(bus.busy),      0);
        check("abort sym_ready", int'(bus.sym_ready), 0);
        bus.sym_valid = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check("abort no out_last", last_cnt - last0, 0);
        run_block(fresh, "after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
